// File: rtl/rule_conf_loader.sv
// Host-side loader for the parser rule-config bus: pairs host words into (addr, data),
// filters illegal info types, buffers them and replays them as single-cycle writes.
module rule_conf_loader #(
   parameter int FIFO_DEPTH    = 16,
   parameter int GAP_CYCLES    = 0,
   parameter int MAX_INFO_TYPE = 5
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_host_valid,
   input  logic [31:0] i_host_data,
   output logic        o_host_ready,
   input  logic        i_flush,
   input  logic        i_clr_err,
   output logic        o_rule_wren,
   output logic [31:0] o_rule_addr,
   output logic [31:0] o_rule_wdata,
   output logic        o_busy,
   output logic        o_err_badtype,
   output logic [15:0] o_wr_cnt,
   output logic [15:0] o_drop_cnt
);
   localparam int AW = $clog2(FIFO_DEPTH);

   localparam logic       PH_ADDR = 1'b0;
   localparam logic       PH_DATA = 1'b1;
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_GAP  = 1'b1;

   localparam logic [3:0] GAP_LD = 4'(GAP_CYCLES);
   localparam logic [2:0] MAX_T  = 3'(MAX_INFO_TYPE);

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
   } pair_t;

   pair_t         mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic          phase;
   logic [0:0]    state;
   logic [3:0]    gap_cnt;
   logic [31:0]   addr_q;

   logic fifo_full, fifo_empty, hs, type_ok, push, drop, pop;

   assign fifo_full  = (count == (AW+1)'(FIFO_DEPTH));
   assign fifo_empty = (count == '0);

   // Full is judged on start-of-cycle occupancy, so a same-cycle pop never frees a slot.
   always_comb begin
      o_host_ready = 1'b0;
      if (!i_rst && !i_flush)
         o_host_ready = (phase == PH_ADDR) || !fifo_full;
   end

   assign hs      = i_host_valid & o_host_ready;
   assign type_ok = (addr_q[10:8] <= MAX_T);
   assign push    = hs & (phase == PH_DATA) & type_ok;
   assign drop    = hs & (phase == PH_DATA) & ~type_ok;
   assign pop     = ~i_flush & (state == ST_IDLE) & ~fifo_empty;

   assign o_busy = ~fifo_empty | (phase == PH_DATA) | (state == ST_GAP) | o_rule_wren;

   always_ff @(posedge i_clk) begin
      if (push) mem[wr_ptr] <= '{addr: addr_q, data: i_host_data};
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         phase  <= PH_ADDR;
         addr_q <= '0;
      end else if (i_flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         phase  <= PH_ADDR;
      end else begin
         if (hs) begin
            if (phase == PH_ADDR) addr_q <= i_host_data;
            phase <= ~phase;
         end
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Issue side: a pop registers the head and strobes wren on the following cycle.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state        <= ST_IDLE;
         gap_cnt      <= '0;
         o_rule_wren  <= 1'b0;
         o_rule_addr  <= '0;
         o_rule_wdata <= '0;
         o_wr_cnt     <= '0;
      end else begin
         o_rule_wren <= pop;
         if (pop) begin
            o_rule_addr  <= mem[rd_ptr].addr;
            o_rule_wdata <= mem[rd_ptr].data;
            if (o_wr_cnt != 16'hFFFF) o_wr_cnt <= o_wr_cnt + 16'd1;
         end
         if (i_flush) begin
            state   <= ST_IDLE;
            gap_cnt <= '0;
         end else if (state == ST_IDLE) begin
            if (pop && GAP_LD != 4'd0) begin
               state   <= ST_GAP;
               gap_cnt <= GAP_LD;
            end
         end else begin
            gap_cnt <= gap_cnt - 4'd1;
            if (gap_cnt == 4'd1) state <= ST_IDLE;
         end
      end
   end

   // A fresh bad pair outranks a clear in the same cycle.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_err_badtype <= 1'b0;
         o_drop_cnt    <= '0;
      end else begin
         if (drop)           o_err_badtype <= 1'b1;
         else if (i_clr_err) o_err_badtype <= 1'b0;
         if (drop && o_drop_cnt != 16'hFFFF) o_drop_cnt <= o_drop_cnt + 16'd1;
      end
   end
endmodule

// File: tb/tb_rule_conf_loader.sv
// Directed bench for rule_conf_loader: one instance with no write gap, one with a 3-cycle gap.
module tb_rule_conf_loader;
   logic        i_clk = 1'b0;
   logic        i_rst = 1'b1;
   logic        v0 = 1'b0, v1 = 1'b0;
   logic [31:0] hdata = '0;
   logic        i_flush = 1'b0, i_clr_err = 1'b0;

   logic        ready, wren, busy, err;
   logic [31:0] addr, wdata;
   logic [15:0] wr_cnt, drop_cnt;
   logic        g_ready, g_wren, g_busy, g_err;
   logic [31:0] g_addr, g_wdata;
   logic [15:0] g_wr_cnt, g_drop_cnt;

   int n_vec = 0, n_err = 0, cyc = 0;
   logic [31:0] qa[$], qd[$], ga[$], gd[$];
   int g_cyc[$];
   bit stall_seen = 1'b0;

   always #5 i_clk = ~i_clk;

   rule_conf_loader #(.FIFO_DEPTH(16), .GAP_CYCLES(0), .MAX_INFO_TYPE(5)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_host_valid(v0), .i_host_data(hdata),
      .o_host_ready(ready), .i_flush(i_flush), .i_clr_err(i_clr_err),
      .o_rule_wren(wren), .o_rule_addr(addr), .o_rule_wdata(wdata), .o_busy(busy),
      .o_err_badtype(err), .o_wr_cnt(wr_cnt), .o_drop_cnt(drop_cnt));

   rule_conf_loader #(.FIFO_DEPTH(16), .GAP_CYCLES(3), .MAX_INFO_TYPE(5)) dut_g (
      .i_clk(i_clk), .i_rst(i_rst), .i_host_valid(v1), .i_host_data(hdata),
      .o_host_ready(g_ready), .i_flush(i_flush), .i_clr_err(i_clr_err),
      .o_rule_wren(g_wren), .o_rule_addr(g_addr), .o_rule_wdata(g_wdata), .o_busy(g_busy),
      .o_err_badtype(g_err), .o_wr_cnt(g_wr_cnt), .o_drop_cnt(g_drop_cnt));

   always @(posedge i_clk) cyc <= cyc + 1;

   always @(negedge i_clk) begin
      if (wren) begin qa.push_back(addr); qd.push_back(wdata); end
      if (g_wren) begin ga.push_back(g_addr); gd.push_back(g_wdata); g_cyc.push_back(cyc); end
      if (v1 && !g_ready && !i_rst && !i_flush) stall_seen = 1'b1;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #2;
   endtask

   task automatic send_word(input logic [31:0] w, input bit which);
      bit done = 1'b0;
      hdata = w;
      if (which) v1 = 1'b1; else v0 = 1'b1;
      for (int k = 0; k < 400; k++) begin
         #1;
         if (which ? g_ready : ready) begin tick(); done = 1'b1; break; end
         tick();
      end
      v0 = 1'b0;
      v1 = 1'b0;
      if (!done) chk("handshake_timeout", 64'(done), 64'd1);
   endtask

   task automatic send_pair(input logic [31:0] a, input logic [31:0] d, input bit which);
      send_word(a, which);
      send_word(d, which);
   endtask

   task automatic wait_idle(input bit which, input int lim);
      for (int k = 0; k < lim; k++) begin
         if (!(which ? g_busy : busy)) break;
         tick();
      end
      chk("idle_timeout", 64'(which ? g_busy : busy), 64'd0);
   endtask

   task automatic do_reset();
      i_rst = 1'b1; v0 = 1'b0; v1 = 1'b0; i_flush = 1'b0; i_clr_err = 1'b0;
      tick(); tick();
      i_rst = 1'b0;
      tick();
      qa.delete(); qd.delete(); ga.delete(); gd.delete(); g_cyc.delete();
   endtask

   initial begin
      int n0;
      // Reset state
      tick(); tick();
      #1;
      chk("rst_ready", 64'(ready), 64'd0);
      chk("rst_wren", 64'(wren), 64'd0);
      chk("rst_addr", 64'(addr), 64'd0);
      chk("rst_wdata", 64'(wdata), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_err", 64'(err), 64'd0);
      chk("rst_wr_cnt", 64'(wr_cnt), 64'd0);
      chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
      i_rst = 1'b0;
      tick();
      chk("ready_after_rst", 64'(ready), 64'd1);
      qa.delete(); qd.delete(); ga.delete(); gd.delete(); g_cyc.delete();

      // 1: single pair, strobe two cycles after the data handshake
      send_pair(32'h0000_0305, 32'h0001_0012, 1'b0);
      chk("t1_wren_n1", 64'(wren), 64'd0);
      chk("t1_busy_n1", 64'(busy), 64'd1);
      tick();
      chk("t1_wren_n2", 64'(wren), 64'd1);
      chk("t1_addr", 64'(addr), 64'h305);
      chk("t1_wdata", 64'(wdata), 64'h10012);
      chk("t1_wr_cnt", 64'(wr_cnt), 64'd1);
      chk("t1_busy_n2", 64'(busy), 64'd1);
      tick();
      chk("t1_wren_n3", 64'(wren), 64'd0);
      chk("t1_busy_n3", 64'(busy), 64'd0);
      chk("t1_addr_hold", 64'(addr), 64'h305);

      // 2: 20 back-to-back pairs, issued in order
      do_reset();
      for (int i = 0; i < 20; i++) send_pair(32'h0000_0100 + 32'(i), 32'hA000_0000 + 32'(i), 1'b0);
      wait_idle(1'b0, 100);
      chk("t2_count", 64'(qa.size()), 64'd20);
      for (int i = 0; i < 20 && i < qa.size(); i++) begin
         chk("t2_addr", 64'(qa[i]), 64'(32'h0000_0100 + 32'(i)));
         chk("t2_data", 64'(qd[i]), 64'(32'hA000_0000 + 32'(i)));
      end
      chk("t2_wr_cnt", 64'(wr_cnt), 64'd20);

      // 2b/3: gap instance fills up, backpressures, and spaces strobes 4 cycles apart
      do_reset();
      stall_seen = 1'b0;
      for (int i = 0; i < 40; i++) send_pair(32'h0000_0200 + 32'(i), 32'hB000_0000 + 32'(i), 1'b1);
      wait_idle(1'b1, 400);
      chk("t3_stall_seen", 64'(stall_seen), 64'd1);
      chk("t3_count", 64'(ga.size()), 64'd40);
      chk("t3_wr_cnt", 64'(g_wr_cnt), 64'd40);
      for (int i = 0; i < 40 && i < ga.size(); i++) begin
         chk("t3_addr", 64'(ga[i]), 64'(32'h0000_0200 + 32'(i)));
         chk("t3_data", 64'(gd[i]), 64'(32'hB000_0000 + 32'(i)));
      end
      for (int i = 1; i < g_cyc.size(); i++)
         chk("t3_spacing", 64'(g_cyc[i] - g_cyc[i-1]), 64'd4);

      // 4: illegal info type dropped; clear loses to a simultaneous bad pair
      do_reset();
      send_pair(32'h0000_0100, 32'h0000_0011, 1'b0);
      send_pair(32'h0000_0700, 32'h0000_0BAD, 1'b0);
      send_pair(32'h0000_0200, 32'h0000_0022, 1'b0);
      wait_idle(1'b0, 50);
      chk("t4_count", 64'(qa.size()), 64'd2);
      if (qa.size() == 2) begin
         chk("t4_addr0", 64'(qa[0]), 64'h100);
         chk("t4_data0", 64'(qd[0]), 64'h11);
         chk("t4_addr1", 64'(qa[1]), 64'h200);
         chk("t4_data1", 64'(qd[1]), 64'h22);
      end
      chk("t4_err", 64'(err), 64'd1);
      chk("t4_drop", 64'(drop_cnt), 64'd1);
      chk("t4_wr_cnt", 64'(wr_cnt), 64'd2);
      send_word(32'h0000_0600, 1'b0);
      hdata = 32'h0000_DEAD; v0 = 1'b1; i_clr_err = 1'b1;
      #1;
      chk("t4_ready_data", 64'(ready), 64'd1);
      tick();
      v0 = 1'b0; i_clr_err = 1'b0;
      chk("t4_err_wins", 64'(err), 64'd1);
      chk("t4_drop2", 64'(drop_cnt), 64'd2);
      i_clr_err = 1'b1;
      tick();
      i_clr_err = 1'b0;
      chk("t4_err_clr", 64'(err), 64'd0);
      send_pair(32'h0000_0500, 32'h0000_0055, 1'b0);
      wait_idle(1'b0, 50);
      chk("t4_type5_count", 64'(qa.size()), 64'd3);
      if (qa.size() == 3) chk("t4_type5_addr", 64'(qa[2]), 64'h500);
      chk("t4_drop_final", 64'(drop_cnt), 64'd2);

      // 5: flush with buffered pairs and a half-assembled pair
      do_reset();
      for (int i = 0; i < 5; i++) send_pair(32'h0000_0400 + 32'(i), 32'hC000_0000 + 32'(i), 1'b1);
      send_word(32'h0000_0444, 1'b1);
      n0 = ga.size();
      hdata = 32'h0000_0ABC; v1 = 1'b1; i_flush = 1'b1;
      #1;
      chk("t5_ready_flush", 64'(g_ready), 64'd0);
      tick();
      i_flush = 1'b0; v1 = 1'b0;
      tick();
      chk("t5_busy", 64'(g_busy), 64'd0);
      for (int k = 0; k < 8; k++) tick();
      chk("t5_strobes", 64'(ga.size() <= n0 + 1), 64'd1);
      chk("t5_wr_cnt", 64'(g_wr_cnt), 64'(ga.size()));
      n0 = ga.size();
      send_pair(32'h0000_0300, 32'h0000_0033, 1'b1);
      wait_idle(1'b1, 50);
      chk("t5_next_count", 64'(ga.size()), 64'(n0 + 1));
      if (ga.size() == n0 + 1) begin
         chk("t5_next_addr", 64'(ga[n0]), 64'h300);
         chk("t5_next_data", 64'(gd[n0]), 64'h33);
      end

      // 6: reset with a loaded FIFO while the gap instance is in GAP
      do_reset();
      for (int i = 0; i < 16; i++) send_pair(32'h0000_0100 + 32'(i), 32'hD000_0000 + 32'(i), 1'b1);
      for (int k = 0; k < 20; k++) begin
         if (g_wren) break;
         tick();
      end
      chk("t6_wren_seen", 64'(g_wren), 64'd1);
      tick();
      chk("t6_busy_pre", 64'(g_busy), 64'd1);
      i_rst = 1'b1;
      tick();
      n0 = ga.size();
      #1;
      chk("t6_ready", 64'(g_ready), 64'd0);
      chk("t6_wren", 64'(g_wren), 64'd0);
      chk("t6_addr", 64'(g_addr), 64'd0);
      chk("t6_wdata", 64'(g_wdata), 64'd0);
      chk("t6_busy", 64'(g_busy), 64'd0);
      chk("t6_err", 64'(g_err), 64'd0);
      chk("t6_wr_cnt", 64'(g_wr_cnt), 64'd0);
      chk("t6_drop_cnt", 64'(g_drop_cnt), 64'd0);
      tick();
      i_rst = 1'b0;
      tick();
      chk("t6_ready_after", 64'(g_ready), 64'd1);
      for (int k = 0; k < 10; k++) tick();
      chk("t6_no_wren", 64'(ga.size()), 64'(n0));
      chk("t6_idle", 64'(g_busy), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
